// File: rtl/serial_fullsub.sv
// rtl/serial_fullsub.sv - digit-serial subtractor diff = a - b - bin with start/done handshake
//
// Purpose: computes a - b - bin over WIDTH/DIGIT cycles using DIGIT chained
// full-subtractor cells, holding the borrow in a register between digits.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request, accepted when not busy
//   a, b   - minuend / subtrahend (WIDTH bits), captured on accept
//   bin    - borrow-in, captured on accept
//   busy   - high while the subtraction is running
//   done   - one-cycle pulse when the result is valid
//   diff   - result modulo 2^WIDTH
//   borrow - unsigned borrow-out of the MSB
//   ovf    - two's-complement overflow
//   zero   - diff == 0
module serial_fullsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               br_q, br_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               amsb_q, amsb_d;
    logic               bmsb_q, bmsb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [DIGIT-1:0]       dig;
    logic [DIGIT:0]         chain;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_shift;
    logic                   last;

    // One digit of ripple full-subtractor cells, LSB first.
    always_comb begin
        chain    = '0;
        chain[0] = br_q;
        dig      = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i]       = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i+1]   = (~a_q[i] & b_q[i]) | (chain[i] & ~(a_q[i] ^ b_q[i]));
        end
    end

    // New digit enters the result from the MSB side; after K digits the
    // first digit has walked down to bit 0.
    assign res_cat   = {dig, res_q};
    assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last      = (cnt_q == CW'(K - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    // Operand MSBs are kept because a_q/b_q are shifted away.
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = res_shift;
                br_d  = chain[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    diff_d   = res_shift;
                    borrow_d = chain[DIGIT];
                    ovf_d    = (amsb_q != bmsb_q) && (res_shift[WIDTH-1] != amsb_q);
                    zero_d   = ~|res_shift;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_fullsub.sv
// tb/tb_serial_fullsub.sv - directed and sweep bench for serial_fullsub in four configurations
module tb_serial_fullsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = '0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       bin_in = 1'b0;

    logic       busy_0, done_0, borrow_0, ovf_0, zero_0;
    logic [7:0] diff_0;
    logic       busy_1, done_1, borrow_1, ovf_1, zero_1;
    logic [7:0] diff_1;
    logic       busy_2, done_2, borrow_2, ovf_2, zero_2;
    logic [3:0] diff_2;
    logic       busy_3, done_3, borrow_3, ovf_3, zero_3;
    logic [3:0] diff_3;

    int n_pass  = 0;
    int n_total = 0;
    int cyc_now = 0;
    int sel     = 0;

    always #5 clk = ~clk;

    serial_fullsub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy_0), .done(done_0), .diff(diff_0), .borrow(borrow_0), .ovf(ovf_0), .zero(zero_0));
    serial_fullsub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy_1), .done(done_1), .diff(diff_1), .borrow(borrow_1), .ovf(ovf_1), .zero(zero_1));
    serial_fullsub #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[3:0]), .b(b_in[3:0]), .bin(bin_in),
        .busy(busy_2), .done(done_2), .diff(diff_2), .borrow(borrow_2), .ovf(ovf_2), .zero(zero_2));
    serial_fullsub #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a_in[3:0]), .b(b_in[3:0]), .bin(bin_in),
        .busy(busy_3), .done(done_3), .diff(diff_3), .borrow(borrow_3), .ovf(ovf_3), .zero(zero_3));

    logic       o_busy, o_done, o_borrow, o_ovf, o_zero;
    logic [7:0] o_diff;

    always_comb begin
        o_busy = busy_0; o_done = done_0; o_diff = diff_0;
        o_borrow = borrow_0; o_ovf = ovf_0; o_zero = zero_0;
        case (sel)
            1: begin
                o_busy = busy_1; o_done = done_1; o_diff = diff_1;
                o_borrow = borrow_1; o_ovf = ovf_1; o_zero = zero_1;
            end
            2: begin
                o_busy = busy_2; o_done = done_2; o_diff = {4'h0, diff_2};
                o_borrow = borrow_2; o_ovf = ovf_2; o_zero = zero_2;
            end
            3: begin
                o_busy = busy_3; o_done = done_3; o_diff = {4'h0, diff_3};
                o_borrow = borrow_3; o_ovf = ovf_3; o_zero = zero_3;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc_now++;
    endtask

    task automatic wait_done(input int t0, input int lim);
        while (!o_done && (cyc_now - t0) < lim) step();
    endtask

    task automatic check_res(input string tag, input logic [7:0] ed, input logic eb,
                             input logic eo, input logic ez);
        check({tag, " diff"}, 32'(o_diff), 32'(ed));
        check({tag, " borrow"}, 32'(o_borrow), 32'(eb));
        check({tag, " ovf"}, 32'(o_ovf), 32'(eo));
        check({tag, " zero"}, 32'(o_zero), 32'(ez));
    endtask

    // One complete operation on instance s with latency, busy and pulse checks.
    task automatic op(input int s, input int k, input logic [7:0] a, input logic [7:0] b,
                      input logic bi, input logic [7:0] ed, input logic eb, input logic eo,
                      input logic ez, input string tag);
        int t0;
        int bad;
        sel = s;
        a_in = a; b_in = b; bin_in = bi;
        t0 = cyc_now;
        start_v = 4'(1 << s);
        step();
        start_v = '0;
        bad = 0;
        while (!o_done && (cyc_now - t0) < 40) begin
            if (!o_busy) bad++;
            step();
        end
        check({tag, " latency"}, 32'(cyc_now - t0), 32'(k + 1));
        check({tag, " busy"}, 32'(bad), 32'd0);
        check({tag, " busy@done"}, 32'(o_busy), 32'd0);
        check_res(tag, ed, eb, eo, ez);
        step();
        check({tag, " pulse"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int ndone;
        int full;
        logic [3:0] ed4;
        logic eb4, eo4;

        step();
        step();
        rst = 1'b0;
        sel = 0;
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst done", 32'(o_done), 32'd0);
        check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst others", 32'({busy_1, done_1, busy_2, done_2, busy_3, done_3}), 32'd0);

        op(0, 8, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "w8d1 5-3");
        op(0, 8, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "w8d1 3-5");
        op(0, 8, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "w8d1 80-1");
        op(0, 8, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "w8d1 0-0-1");
        op(0, 8, 8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "w8d1 1-0-1");
        op(1, 2, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0, "w8d4 A5-5A");

        // start pulsed and operands changed while running
        sel = 0;
        t0 = cyc_now;
        a_in = 8'h05; b_in = 8'h03; bin_in = 1'b0;
        start_v = 4'b0001;
        step();
        start_v = '0;
        step();
        step();
        a_in = 8'hFF; b_in = 8'h11; bin_in = 1'b1;
        start_v = 4'b0001;
        step();
        start_v = '0;
        wait_done(t0, 40);
        check("midrun latency", 32'(cyc_now - t0), 32'd9);
        check_res("midrun", 8'h02, 1'b0, 1'b0, 1'b0);
        step();
        check("midrun pulse", 32'(o_done), 32'd0);

        // start held high through DONE
        t0 = cyc_now;
        a_in = 8'h05; b_in = 8'h03; bin_in = 1'b0;
        start_v = 4'b0001;
        step();
        a_in = 8'h20; b_in = 8'h01;
        wait_done(t0, 40);
        check("held latency", 32'(cyc_now - t0), 32'd9);
        check_res("held first", 8'h02, 1'b0, 1'b0, 1'b0);
        t1 = cyc_now;
        step();
        start_v = '0;
        check("held done drop", 32'(o_done), 32'd0);
        check("held busy again", 32'(o_busy), 32'd1);
        wait_done(t1, 40);
        check("held2 latency", 32'(cyc_now - t1), 32'd9);
        check_res("held second", 8'h1F, 1'b0, 1'b0, 1'b0);
        step();

        // reset in RUN cycle 4 aborts without done
        a_in = 8'h80; b_in = 8'h01; bin_in = 1'b0;
        start_v = 4'b0001;
        step();
        start_v = '0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("abort busy", 32'(o_busy), 32'd0);
        check("abort done", 32'(o_done), 32'd0);
        check_res("abort", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_done) ndone++;
            step();
        end
        check("abort no done", 32'(ndone), 32'd0);
        op(0, 8, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "after abort");

        // exhaustive 4-bit sweep against a - b - bin
        for (int s = 2; s <= 3; s++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        full = ai - bi - ci;
                        ed4  = 4'(full);
                        eb4  = (full < 0);
                        eo4  = (ai[3] != bi[3]) && (ed4[3] != ai[3]);
                        op(s, (s == 2) ? 4 : 2, 8'(ai), 8'(bi), ci[0],
                           {4'h0, ed4}, eb4, eo4, (ed4 == 4'h0),
                           (s == 2) ? "w4d1 sweep" : "w4d2 sweep");
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
